// File: rtl/wbs_stream_bridge_if.sv
// Bus bundle for wbs_stream_bridge: the Wishbone slave signals, the
// outbound beat stream toward the ANN core loaders and the inbound
// result-index stream from the core.
interface wbs_stream_bridge_if #(
    parameter int DATA_WIDTH = 11
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_region;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output out_valid, out_data, out_region,
        input  out_ready,
        input  in_valid, in_data,
        output in_ready
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  out_valid, out_data, out_region,
        output out_ready,
        output in_valid, in_data,
        input  in_ready
    );
endinterface

// File: rtl/wbs_stream_bridge.sv
// Wishbone slave front end for the ANN accelerator core.
// A control page (MODE, DEBUG, DONE, FSM_START, FSM_BUSY) sits at BASE_ADDR.
// Writes to the NODE/LEAF/QUERY windows are unpacked into NUM_FIELDS beats
// of DATA_WIDTH bits on a valid/ready stream; reads of the BEST window pop
// one result index from the inbound stream.
// Optional build macro WBS_BEST_TIMEOUT_EN: a BEST read that sees no result
// within TIMEOUT_CYCLES cycles acks with 32'hDEAD_0000 and sets DONE bit1.
// NUM_FIELDS must lie in 1..floor(32/DATA_WIDTH).
module wbs_stream_bridge #(
    parameter int          DATA_WIDTH     = 11,
    parameter int          NUM_FIELDS     = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    wbs_stream_bridge_if.slave   bus,
    output logic                 load_kdtree,
    output logic                 fsm_start,
    input  logic                 fsm_busy,
    input  logic                 fsm_done
);

    // One page is the lowest address bit selected by ADDR_MASK.
    localparam logic [31:0] PAGE_STEP  = ADDR_MASK & (~ADDR_MASK + 32'd1);
    localparam logic [31:0] CTRL_PAGE  = BASE_ADDR & ADDR_MASK;
    localparam logic [31:0] QUERY_PAGE = CTRL_PAGE + PAGE_STEP;
    localparam logic [31:0] LEAF_PAGE  = CTRL_PAGE + 32'd2 * PAGE_STEP;
    localparam logic [31:0] BEST_PAGE  = CTRL_PAGE + 32'd3 * PAGE_STEP;
    localparam logic [31:0] NODE_PAGE  = CTRL_PAGE + 32'd4 * PAGE_STEP;

    localparam logic [15:0] OFS_MODE  = 16'h0000;
    localparam logic [15:0] OFS_DEBUG = 16'h0004;
    localparam logic [15:0] OFS_DONE  = 16'h0008;
    localparam logic [15:0] OFS_START = 16'h000C;
    localparam logic [15:0] OFS_BUSY  = 16'h0010;

    localparam logic [1:0] REGION_NODE  = 2'd0;
    localparam logic [1:0] REGION_LEAF  = 2'd1;
    localparam logic [1:0] REGION_QUERY = 2'd2;

    localparam int BEAT_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_IN,
        S_ACKED
    } state_t;

    state_t              state_q, next_state;

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                start_q, start_d;
    logic                mode_q;
    logic [31:0]         debug_q;
    logic                done_q;
    logic [31:0]         payload_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [1:0]          region_q, region_d;
    logic                cyc_lost_q;

    logic                request;
    logic [31:0]         page;
    logic [15:0]         offset;
    logic                hit_ctrl, hit_query, hit_leaf, hit_best, hit_node;
    logic                hit_stream_win;
    logic                last_beat;
    logic                in_ready_c;
    logic                load_stream;
    logic                mode_we, debug_we, done_wr_clr;
    logic                done_clr;

    assign request        = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign page           = bus.wbs_adr_i & ADDR_MASK;
    assign offset         = bus.wbs_adr_i[15:0];
    assign hit_ctrl       = (page == CTRL_PAGE);
    assign hit_query      = (page == QUERY_PAGE);
    assign hit_leaf       = (page == LEAF_PAGE);
    assign hit_best       = (page == BEST_PAGE);
    assign hit_node       = (page == NODE_PAGE);
    assign hit_stream_win = hit_node | hit_leaf | hit_query;
    assign region_d       = hit_leaf ? REGION_LEAF : (hit_query ? REGION_QUERY : REGION_NODE);
    assign last_beat      = (beat_q == BEAT_W'(NUM_FIELDS - 1));

    // Sticky status is cleared by a DONE write or by the start pulse itself.
    assign done_clr       = done_wr_clr | start_q;

`ifdef WBS_BEST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]    wait_cnt_q;
    logic                timeout_hit;
    logic                timeout_set;
    logic                timeout_q;

    assign timeout_hit = (state_q == S_WAIT_IN) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count BEST-read wait cycles (request cycle counts as the first) and hold the sticky TIMEOUT flag.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == S_WAIT_IN) ? wait_cnt_q + 1'b1 : CNT_W'(1);
            timeout_q  <= timeout_set | (timeout_q & ~done_clr);
        end
    end
`else
    logic                timeout_q;

    assign timeout_q = 1'b0;
`endif

    // State register for the bus-transaction FSM.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state decode, register strobes and the registered ack/data values.
    always_comb begin
        next_state  = state_q;
        ack_d       = 1'b0;
        dat_d       = '0;
        start_d     = 1'b0;
        in_ready_c  = 1'b0;
        load_stream = 1'b0;
        mode_we     = 1'b0;
        debug_we    = 1'b0;
        done_wr_clr = 1'b0;
`ifdef WBS_BEST_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (request) begin
                    if (bus.wbs_we_i && hit_stream_win) begin
                        next_state  = S_STREAM;
                        load_stream = 1'b1;
                    end else if (!bus.wbs_we_i && hit_best) begin
                        next_state = S_WAIT_IN;
                    end else begin
                        next_state = S_ACKED;
                        ack_d      = 1'b1;
                        if (hit_ctrl) begin
                            if (bus.wbs_we_i) begin
                                case (offset)
                                    OFS_MODE:  mode_we     = 1'b1;
                                    OFS_DEBUG: debug_we    = 1'b1;
                                    OFS_DONE:  done_wr_clr = 1'b1;
                                    OFS_START: start_d     = 1'b1;
                                    default:   ;
                                endcase
                            end else begin
                                case (offset)
                                    OFS_MODE:  dat_d = {31'b0, mode_q};
                                    OFS_DEBUG: dat_d = debug_q;
                                    OFS_DONE:  dat_d = {30'b0, timeout_q, done_q};
                                    OFS_BUSY:  dat_d = {31'b0, fsm_busy};
                                    default:   dat_d = '0;
                                endcase
                            end
                        end
                    end
                end
            end
            S_STREAM: begin
                if (bus.out_ready && last_beat) begin
                    if (bus.wbs_cyc_i && !cyc_lost_q) begin
                        next_state = S_ACKED;
                        ack_d      = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_WAIT_IN: begin
                if (!bus.wbs_cyc_i) begin
                    next_state = S_IDLE;
                end else if (bus.in_valid) begin
                    in_ready_c = 1'b1;
                    ack_d      = 1'b1;
                    dat_d      = 32'(bus.in_data);
                    next_state = S_ACKED;
                end
`ifdef WBS_BEST_TIMEOUT_EN
                else if (timeout_hit) begin
                    ack_d       = 1'b1;
                    dat_d       = 32'hDEAD_0000;
                    timeout_set = 1'b1;
                    next_state  = S_ACKED;
                end
`endif
            end
            S_ACKED: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Registered bus response plus the control-page registers.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            start_q <= 1'b0;
            mode_q  <= 1'b0;
            debug_q <= '0;
            done_q  <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            start_q <= start_d;
            if (mode_we) begin
                mode_q <= bus.wbs_dat_i[0];
            end
            if (debug_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.wbs_sel_i[b]) begin
                        debug_q[8*b +: 8] <= bus.wbs_dat_i[8*b +: 8];
                    end
                end
            end
            done_q <= fsm_done | (done_q & ~done_clr);
        end
    end

    // Capture a window write and shift one beat out per accepted handshake.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            payload_q  <= '0;
            beat_q     <= '0;
            region_q   <= REGION_NODE;
            cyc_lost_q <= 1'b0;
        end else if (load_stream) begin
            payload_q  <= bus.wbs_dat_i;
            beat_q     <= '0;
            region_q   <= region_d;
            cyc_lost_q <= 1'b0;
        end else if (state_q == S_STREAM) begin
            if (!bus.wbs_cyc_i) begin
                cyc_lost_q <= 1'b1;
            end
            if (bus.out_ready) begin
                payload_q <= payload_q >> DATA_WIDTH;
                beat_q    <= beat_q + 1'b1;
            end
        end
    end

    assign bus.wbs_ack_o  = ack_q;
    assign bus.wbs_dat_o  = dat_q;
    assign bus.out_valid  = (state_q == S_STREAM);
    assign bus.out_data   = payload_q[DATA_WIDTH-1:0];
    assign bus.out_region = region_q;
    assign bus.in_ready   = in_ready_c;
    assign load_kdtree    = mode_q;
    assign fsm_start      = start_q;

endmodule
